z16_mem_arbiter: RTL and testbench

// - Shares one single-port synchronous memory between the Z16 CPU instruction-fetch (IF) port and data-memory (DM) port.
// - Sits between the Z16CPU core and the unified program/data SRAM.
// - Sequences each access: arbitrate, issue, wait read latency, return data.
// - DM has priority; a starvation guard bounds IF waiting.

---
 rtl/z16_arb_pkg.sv | 17 +
 rtl/z16_arb_perf_ctr.sv | 37 +++
 rtl/z16_mem_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_z16_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/z16_arb_pkg.sv
// z16_arb_pkg: shared types and constants for the Z16 IF/DM memory arbiter.
package z16_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam int PERF_CW = 32;

endpackage

// File: rtl/z16_arb_perf_ctr.sv
// z16_arb_perf_ctr: grant and stall event counters for the Z16 memory arbiter.
// Only present when Z16_ARB_PERF_EN is defined.
`ifdef Z16_ARB_PERF_EN
module z16_arb_perf_ctr
    import z16_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_gnt,
    input  logic               dm_gnt,
    input  logic               stall,
    output logic [PERF_CW-1:0] if_cnt,
    output logic [PERF_CW-1:0] dm_cnt,
    output logic [PERF_CW-1:0] stall_cnt
);

    // Free-running event counters; natural wrap at 2^PERF_CW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_cnt    <= '0;
            dm_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            if (if_gnt) begin
                if_cnt <= if_cnt + PERF_CW'(1);
            end
            if (dm_gnt) begin
                dm_cnt <= dm_cnt + PERF_CW'(1);
            end
            if (stall) begin
                stall_cnt <= stall_cnt + PERF_CW'(1);
            end
        end
    end

endmodule
`endif

// File: rtl/z16_mem_arbiter.sv
// z16_mem_arbiter: shares one single-port synchronous SRAM between the Z16
// instruction-fetch and data-memory ports. DM has priority; a saturating
// starve counter forces IF to win after MAX_WAIT consecutive losses.
// Optional performance counters are built when Z16_ARB_PERF_EN is defined.
module z16_mem_arbiter
    import z16_arb_pkg::*;
#(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_if_req,
    input  logic [AW-1:0]      i_if_addr,
    output logic               o_if_gnt,
    output logic               o_if_rvalid,
    output logic [DW-1:0]      o_if_rdata,
    input  logic               i_dm_req,
    input  logic               i_dm_we,
    input  logic [AW-1:0]      i_dm_addr,
    input  logic [DW-1:0]      i_dm_wdata,
    output logic               o_dm_gnt,
    output logic               o_dm_rvalid,
    output logic [DW-1:0]      o_dm_rdata,
    output logic               o_mem_en,
    output logic               o_mem_we,
    output logic [AW-1:0]      o_mem_addr,
    output logic [DW-1:0]      o_mem_wdata,
`ifdef Z16_ARB_PERF_EN
    output logic [PERF_CW-1:0] o_perf_if_cnt,
    output logic [PERF_CW-1:0] o_perf_dm_cnt,
    output logic [PERF_CW-1:0] o_perf_stall_cnt,
`endif
    input  logic [DW-1:0]      i_mem_rdata
);

    localparam int SCW = $clog2(MAX_WAIT + 1);
    localparam int LCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t         state_r,     state_s;
    owner_t         owner_r,     owner_s;
    logic [SCW-1:0] starve_r,    starve_s;
    logic [LCW-1:0] lat_r,       lat_s;
    logic           mem_en_r,    mem_en_s;
    logic           mem_we_r,    mem_we_s;
    logic [AW-1:0]  mem_addr_r,  mem_addr_s;
    logic [DW-1:0]  mem_wdata_r, mem_wdata_s;
    logic           if_gnt_r,    if_gnt_s;
    logic           dm_gnt_r,    dm_gnt_s;
    logic           if_rvalid_r, if_rvalid_s;
    logic           dm_rvalid_r, dm_rvalid_s;
    logic [DW-1:0]  if_rdata_r;
    logic [DW-1:0]  dm_rdata_r;
    logic           dm_wins_s;
    logic           rv_next_s;

    // Next-state, winner selection and next registered outputs.
    always_comb begin
        state_s     = state_r;
        owner_s     = owner_r;
        starve_s    = starve_r;
        lat_s       = lat_r;
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = '0;
        mem_wdata_s = '0;
        if_gnt_s    = 1'b0;
        dm_gnt_s    = 1'b0;
        rv_next_s   = 1'b0;
        dm_wins_s   = i_dm_req && ((starve_r < SCW'(MAX_WAIT)) || !i_if_req);

        case (state_r)
            ST_IDLE: begin
                if (dm_wins_s) begin
                    state_s     = ST_ACCESS;
                    owner_s     = OWN_DM;
                    dm_gnt_s    = 1'b1;
                    mem_en_s    = 1'b1;
                    mem_we_s    = i_dm_we;
                    mem_addr_s  = i_dm_addr;
                    mem_wdata_s = i_dm_we ? i_dm_wdata : '0;
                    if (i_if_req && (starve_r < SCW'(MAX_WAIT))) begin
                        starve_s = starve_r + SCW'(1);
                    end else if (i_if_req) begin
                        starve_s = starve_r;
                    end else begin
                        starve_s = '0;
                    end
                end else if (i_if_req) begin
                    state_s    = ST_ACCESS;
                    owner_s    = OWN_IF;
                    if_gnt_s   = 1'b1;
                    mem_en_s   = 1'b1;
                    mem_addr_s = i_if_addr;
                    starve_s   = '0;
                end else begin
                    starve_s = '0;
                end
            end
            ST_ACCESS: begin
                if (mem_we_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s   = ST_WAIT;
                    lat_s     = LCW'(RD_LAT - 1);
                    rv_next_s = (RD_LAT == 1);
                end
            end
            ST_WAIT: begin
                if (lat_r == '0) begin
                    state_s = ST_IDLE;
                end else begin
                    lat_s     = lat_r - LCW'(1);
                    rv_next_s = (lat_r == LCW'(1));
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if_rvalid_s = rv_next_s && (owner_r == OWN_IF);
        dm_rvalid_s = rv_next_s && (owner_r == OWN_DM);
    end

    // State, winner and output registers; read data captured on rvalid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= ST_IDLE;
            owner_r     <= OWN_IF;
            starve_r    <= '0;
            lat_r       <= '0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            if_gnt_r    <= 1'b0;
            dm_gnt_r    <= 1'b0;
            if_rvalid_r <= 1'b0;
            dm_rvalid_r <= 1'b0;
            if_rdata_r  <= '0;
            dm_rdata_r  <= '0;
        end else begin
            state_r     <= state_s;
            owner_r     <= owner_s;
            starve_r    <= starve_s;
            lat_r       <= lat_s;
            mem_en_r    <= mem_en_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            if_gnt_r    <= if_gnt_s;
            dm_gnt_r    <= dm_gnt_s;
            if_rvalid_r <= if_rvalid_s;
            dm_rvalid_r <= dm_rvalid_s;
            if (if_rvalid_r) begin
                if_rdata_r <= i_mem_rdata;
            end
            if (dm_rvalid_r) begin
                dm_rdata_r <= i_mem_rdata;
            end
        end
    end

    assign o_mem_en    = mem_en_r;
    assign o_mem_we    = mem_we_r;
    assign o_mem_addr  = mem_addr_r;
    assign o_mem_wdata = mem_wdata_r;
    assign o_if_gnt    = if_gnt_r;
    assign o_dm_gnt    = dm_gnt_r;
    assign o_if_rvalid = if_rvalid_r;
    assign o_dm_rvalid = dm_rvalid_r;
    // Memory data is forwarded in the rvalid cycle and held afterwards.
    assign o_if_rdata  = if_rvalid_r ? i_mem_rdata : if_rdata_r;
    assign o_dm_rdata  = dm_rvalid_r ? i_mem_rdata : dm_rdata_r;

`ifdef Z16_ARB_PERF_EN
    logic stall_s;

    // A cycle stalls when some requester is asserting without its grant.
    always_comb begin
        stall_s = (i_if_req && !if_gnt_r) || (i_dm_req && !dm_gnt_r);
    end

    z16_arb_perf_ctr u_perf (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .if_gnt    (if_gnt_r),
        .dm_gnt    (dm_gnt_r),
        .stall     (stall_s),
        .if_cnt    (o_perf_if_cnt),
        .dm_cnt    (o_perf_dm_cnt),
        .stall_cnt (o_perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_z16_mem_arbiter.sv
// tb_z16_mem_arbiter: directed and randomized checks of z16_mem_arbiter
// against a cycle-number based transaction model (RD_LAT=1, MAX_WAIT=4).
// Perf counter checks are included when Z16_ARB_PERF_EN is defined.
module tb_z16_mem_arbiter;

    localparam int AW       = 16;
    localparam int DW       = 16;
    localparam int RD_LAT   = 1;
    localparam int MAX_WAIT = 4;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_if_req = 1'b0;
    logic [AW-1:0] i_if_addr = '0;
    logic          o_if_gnt, o_if_rvalid;
    logic [DW-1:0] o_if_rdata;
    logic          i_dm_req = 1'b0;
    logic          i_dm_we = 1'b0;
    logic [AW-1:0] i_dm_addr = '0;
    logic [DW-1:0] i_dm_wdata = '0;
    logic          o_dm_gnt, o_dm_rvalid;
    logic [DW-1:0] o_dm_rdata;
    logic          o_mem_en, o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [DW-1:0] i_mem_rdata = '0;
`ifdef Z16_ARB_PERF_EN
    logic [31:0]   o_perf_if_cnt, o_perf_dm_cnt, o_perf_stall_cnt;
`endif

    int n_run  = 0;
    int n_fail = 0;

    // transaction model state (cycle numbers of scheduled events)
    int            nxt, starve, g_edge, rv_edge;
    logic          g_dm, g_we, rv_dm;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wd, rv_data;

    z16_mem_arbiter dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_if_req    (i_if_req),
        .i_if_addr   (i_if_addr),
        .o_if_gnt    (o_if_gnt),
        .o_if_rvalid (o_if_rvalid),
        .o_if_rdata  (o_if_rdata),
        .i_dm_req    (i_dm_req),
        .i_dm_we     (i_dm_we),
        .i_dm_addr   (i_dm_addr),
        .i_dm_wdata  (i_dm_wdata),
        .o_dm_gnt    (o_dm_gnt),
        .o_dm_rvalid (o_dm_rvalid),
        .o_dm_rdata  (o_dm_rdata),
        .o_mem_en    (o_mem_en),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
`ifdef Z16_ARB_PERF_EN
        .o_perf_if_cnt    (o_perf_if_cnt),
        .o_perf_dm_cnt    (o_perf_dm_cnt),
        .o_perf_stall_cnt (o_perf_stall_cnt),
`endif
        .i_mem_rdata (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    // Memory contents as a fixed function of address.
    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        if (a == 16'h0010) return 16'hABCD;
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    // Synchronous read port, one cycle latency.
    always @(posedge i_clk) begin
        if (o_mem_en && !o_mem_we) i_mem_rdata <= mem_f(o_mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_if_gnt"},  o_if_gnt,    32'd0);
        check({tag, "_if_rv"},   o_if_rvalid, 32'd0);
        check({tag, "_if_rd"},   o_if_rdata,  32'd0);
        check({tag, "_dm_gnt"},  o_dm_gnt,    32'd0);
        check({tag, "_dm_rv"},   o_dm_rvalid, 32'd0);
        check({tag, "_dm_rd"},   o_dm_rdata,  32'd0);
        check({tag, "_mem_en"},  o_mem_en,    32'd0);
        check({tag, "_mem_we"},  o_mem_we,    32'd0);
        check({tag, "_mem_ad"},  o_mem_addr,  32'd0);
        check({tag, "_mem_wd"},  o_mem_wdata, 32'd0);
    endtask

    task automatic model_reset();
        nxt = 0; starve = 0; g_edge = -10; rv_edge = -10;
        g_dm = 1'b0; g_we = 1'b0; rv_dm = 1'b0; g_addr = '0; g_wd = '0; rv_data = '0;
    endtask

    // Arbitration decision at edge e from the requests presented now.
    task automatic model_arb(input int e);
        if (e >= nxt) begin
            if (i_dm_req && (starve < MAX_WAIT || !i_if_req)) begin
                starve = i_if_req ? ((starve < MAX_WAIT) ? starve + 1 : starve) : 0;
                g_edge = e; g_dm = 1'b1; g_we = i_dm_we; g_addr = i_dm_addr; g_wd = i_dm_wdata;
            end else if (i_if_req) begin
                starve = 0;
                g_edge = e; g_dm = 1'b0; g_we = 1'b0; g_addr = i_if_addr; g_wd = '0;
            end else begin
                starve = 0;
            end
            if (g_edge == e) begin
                if (g_we) begin
                    nxt = e + 2;
                end else begin
                    nxt = e + 2 + RD_LAT;
                    rv_edge = e + RD_LAT; rv_dm = g_dm; rv_data = mem_f(g_addr);
                end
            end
        end
    endtask

    // Compare outputs observed after edge e with the model's schedule.
    task automatic check_cycle(input int e);
        check("m_if_gnt", o_if_gnt, 32'(g_edge == e && !g_dm));
        check("m_dm_gnt", o_dm_gnt, 32'(g_edge == e && g_dm));
        check("m_mem_en", o_mem_en, 32'(g_edge == e));
        if (g_edge == e) begin
            check("m_mem_we", o_mem_we, 32'(g_we));
            check("m_mem_addr", o_mem_addr, 32'(g_addr));
            if (g_we) check("m_mem_wdata", o_mem_wdata, 32'(g_wd));
        end
        check("m_if_rv", o_if_rvalid, 32'(rv_edge == e && !rv_dm));
        check("m_dm_rv", o_dm_rvalid, 32'(rv_edge == e && rv_dm));
        if (rv_edge == e) begin
            if (rv_dm) check("m_dm_rdata", o_dm_rdata, 32'(rv_data));
            else       check("m_if_rdata", o_if_rdata, 32'(rv_data));
        end
    endtask

    initial begin
        int n_g;
        int if_left, dm_left, stall_exp;

        // reset state
        repeat (2) tick();
        check_all_zero("rst");
        i_rst_n = 1'b1;
        tick();

        // IF read alone
        i_if_req = 1'b1; i_if_addr = 16'h0010;
        tick();
        check("if_gnt", o_if_gnt, 32'd1);
        check("if_en", o_mem_en, 32'd1);
        check("if_we", o_mem_we, 32'd0);
        check("if_addr", o_mem_addr, 32'h0010);
        check("if_no_dm_gnt", o_dm_gnt, 32'd0);
        i_if_req = 1'b0;
        tick();
        check("if_rvalid", o_if_rvalid, 32'd1);
        check("if_rdata", o_if_rdata, 32'hABCD);
        check("if_no_dm_rv", o_dm_rvalid, 32'd0);
        tick();
        check("if_rvalid_pulse", o_if_rvalid, 32'd0);
        check("if_rdata_hold", o_if_rdata, 32'hABCD);

        // DM writes back to back
        i_dm_req = 1'b1; i_dm_we = 1'b1; i_dm_addr = 16'h0020; i_dm_wdata = 16'h1234;
        tick();
        check("wr_gnt", o_dm_gnt, 32'd1);
        check("wr_en", o_mem_en, 32'd1);
        check("wr_we", o_mem_we, 32'd1);
        check("wr_addr", o_mem_addr, 32'h0020);
        check("wr_wdata", o_mem_wdata, 32'h1234);
        i_dm_addr = 16'h0021; i_dm_wdata = 16'h5678;
        tick();
        check("wr_gap_gnt", o_dm_gnt, 32'd0);
        check("wr_gap_en", o_mem_en, 32'd0);
        check("wr_no_rv", o_dm_rvalid, 32'd0);
        tick();
        check("wr2_gnt", o_dm_gnt, 32'd1);
        check("wr2_addr", o_mem_addr, 32'h0021);
        check("wr2_wdata", o_mem_wdata, 32'h5678);
        i_dm_req = 1'b0;
        tick();
        check("wr2_no_rv", o_dm_rvalid, 32'd0);

        // contention: continuous reads on both ports
        i_if_req = 1'b1; i_if_addr = 16'h0100;
        i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 16'h0200;
        n_g = 0;
        for (int c = 0; c < 60 && n_g < 10; c++) begin
            tick();
            check("cont_one_gnt", 32'(o_if_gnt && o_dm_gnt), 32'd0);
            if (o_if_gnt || o_dm_gnt) begin
                check("cont_order_dm", 32'(o_dm_gnt), (n_g % 5 == 4) ? 32'd0 : 32'd1);
                n_g++;
            end
        end
        check("cont_count", n_g, 32'd10);
        i_if_req = 1'b0; i_dm_req = 1'b0;
        repeat (3) tick();

        // DM pulse while busy is ignored; held IF request wins afterwards
        i_if_req = 1'b1; i_if_addr = 16'h0030;
        tick();
        check("wd_if_gnt0", o_if_gnt, 32'd1);
        i_if_addr = 16'h0031; i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 16'h0040;
        tick();
        check("wd_dm_gnt_a", o_dm_gnt, 32'd0);
        i_dm_req = 1'b0;
        tick();
        check("wd_dm_gnt_b", o_dm_gnt, 32'd0);
        check("wd_if_gnt_idle", o_if_gnt, 32'd0);
        tick();
        check("wd_if_gnt1", o_if_gnt, 32'd1);
        check("wd_dm_gnt_c", o_dm_gnt, 32'd0);
        check("wd_addr", o_mem_addr, 32'h0031);
        i_if_req = 1'b0;
        repeat (2) tick();

        // reset asserted during the WAIT cycle of a DM read
        i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 16'h0040;
        tick();
        check("rw_dm_gnt", o_dm_gnt, 32'd1);
        i_dm_req = 1'b0;
        @(posedge i_clk);
        #1 i_rst_n = 1'b0;
        #1 check_all_zero("rw");
        tick();
        tick();
        i_rst_n = 1'b1;
        repeat (3) begin
            tick();
            check("rw_no_dm_rv", o_dm_rvalid, 32'd0);
            check("rw_no_if_rv", o_if_rvalid, 32'd0);
            check("rw_no_gnt", 32'(o_if_gnt || o_dm_gnt), 32'd0);
        end
        i_if_req = 1'b1; i_if_addr = 16'h0010;
        tick();
        check("rw_if_gnt", o_if_gnt, 32'd1);
        i_if_req = 1'b0;
        tick();
        check("rw_if_rdata", o_if_rdata, 32'hABCD);
        repeat (2) tick();

        // randomized traffic against the transaction model
        model_reset();
        for (int e = 0; e < 400; e++) begin
            if (!i_if_req && $urandom_range(0, 2) == 0) begin
                i_if_req = 1'b1; i_if_addr = 16'($urandom);
            end
            if (!i_dm_req && $urandom_range(0, 2) == 0) begin
                i_dm_req = 1'b1; i_dm_we = 1'($urandom_range(0, 1));
                i_dm_addr = 16'($urandom); i_dm_wdata = 16'($urandom);
            end
            model_arb(e);
            tick();
            check_cycle(e);
            if (g_edge == e) begin
                if (g_dm) i_dm_req = 1'b0;
                else      i_if_req = 1'b0;
            end
        end
        i_if_req = 1'b0; i_dm_req = 1'b0;
        repeat (4) tick();

`ifdef Z16_ARB_PERF_EN
        // perf counters: 3 IF reads and 2 DM writes issued together
        i_rst_n = 1'b0;
        tick();
        check("perf_rst_if", o_perf_if_cnt, 32'd0);
        check("perf_rst_dm", o_perf_dm_cnt, 32'd0);
        check("perf_rst_st", o_perf_stall_cnt, 32'd0);
        i_rst_n = 1'b1;
        tick();
        model_reset();
        if_left = 3; dm_left = 2; stall_exp = 0;
        i_if_req = 1'b1; i_if_addr = 16'h0300;
        i_dm_req = 1'b1; i_dm_we = 1'b1; i_dm_addr = 16'h0400; i_dm_wdata = 16'h1111;
        for (int e = 0; e < 40 && (if_left > 0 || dm_left > 0); e++) begin
            if ((i_if_req && !(g_edge == e - 1 && !g_dm)) || (i_dm_req && !(g_edge == e - 1 && g_dm)))
                stall_exp++;
            model_arb(e);
            tick();
            check_cycle(e);
            if (g_edge == e && !g_dm) begin
                if_left--;
                if (if_left == 0) i_if_req = 1'b0;
                else i_if_addr = i_if_addr + 16'h0001;
            end
            if (g_edge == e && g_dm) begin
                dm_left--;
                if (dm_left == 0) i_dm_req = 1'b0;
                else begin i_dm_addr = i_dm_addr + 16'h0001; i_dm_wdata = i_dm_wdata + 16'h0001; end
            end
        end
        check("perf_done", 32'(if_left + dm_left), 32'd0);
        repeat (3) tick();
        check("perf_if_cnt", o_perf_if_cnt, 32'd3);
        check("perf_dm_cnt", o_perf_dm_cnt, 32'd2);
        check("perf_stall_cnt", o_perf_stall_cnt, 32'(stall_exp));
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
